// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    typedef logic [31:0] word_t;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned BE_W  = 4;

    // Misaligned, or word index (modulo 2^32 offset from base) outside the array.
    function automatic logic addr_err(input word_t addr, input word_t base,
                                      input int unsigned depth);
        word_t off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ((off >> 2) >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH_WORDS x 32 storage: synchronous byte-masked write, combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
)(
    input  logic            clk,
    input  logic            i_we,
    input  logic [BE_W-1:0] i_wmask,
    input  logic [AW-1:0]   i_addr,
    input  word_t           i_wdata,
    output word_t           o_rdata_c
);

    word_t r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: one request at a time, fixed LATENCY, error flagging.
// Define DMEM_BYTE_LANES_EN to honour req_be on stores; otherwise stores write the full word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2,
    parameter word_t       BASE_ADDR   = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  word_t           req_addr,
    input  word_t           req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output word_t           rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_t      r_state, w_state_nxt;
    logic             w_accept, w_commit, w_hs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write, r_err;
    logic [AW-1:0]    r_idx;
    word_t            r_wdata;
    logic [BE_W-1:0]  r_be;
    word_t            w_offset, w_rdata_c;
    logic [BE_W-1:0]  w_wmask;
    logic             w_we;
    logic             r_req_ready, r_rsp_valid, r_rsp_err;
    word_t            r_rsp_rdata;

    assign w_offset = req_addr - BASE_ADDR;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            IDLE: if (req_valid && r_req_ready) begin
                w_accept    = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: if (r_cnt == '0) begin
                w_commit    = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: if (rsp_ready && r_rsp_valid) begin
                w_hs        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture and latency countdown.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_write <= req_write;
            r_err   <= addr_err(req_addr, BASE_ADDR, DEPTH_WORDS);
            r_idx   <= AW'(w_offset >> 2);
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end else if (r_state == WAIT && r_cnt != '0) begin
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

`ifdef DMEM_BYTE_LANES_EN
    assign w_wmask = r_be;
`else
    // Byte enables are don't-care here: every store writes all four lanes.
    assign w_wmask = r_be | {BE_W{1'b1}};
`endif

    assign w_we = w_commit && r_write && !r_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_wmask   (w_wmask),
        .i_addr    (r_idx),
        .i_wdata   (r_wdata),
        .o_rdata_c (w_rdata_c)
    );

    // Registered handshake and response outputs, following the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            if (w_commit) begin
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (!r_write && !r_err) ? w_rdata_c : '0;
            end else if (w_hs) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus random traffic against a word-array model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_mem [DEPTH];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_err(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (addr % 4 != 0) || (off / 4 >= DEPTH);
    endfunction

    // One full transaction: request, latency, optional backpressure, handshake.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int hold, output logic [31:0] got);
        int          waits, lat, idx;
        bit          err;
        logic [31:0] exp_rd;
        logic [3:0]  lanes;
        err    = m_err(addr);
        idx    = int'((addr - BASE) / 4);
        exp_rd = 32'h0;
        if (!wr && !err) exp_rd = m_mem[idx];
`ifdef DMEM_BYTE_LANES_EN
        lanes = be;
`else
        lanes = 4'hF;
`endif
        if (wr && !err)
            for (int b = 0; b < 4; b++)
                if (lanes[b]) m_mem[idx][8*b +: 8] = data[8*b +: 8];

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_be    = be;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk_eq("accept_wait", waits, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rsp_valid && lat < 20);
        chk_eq("latency", lat, LAT);
        chk_eq("rsp_err", rsp_err, err);
        chk_eq("rsp_rdata", rsp_rdata, exp_rd);
        chk_eq("ready_busy", req_ready, 1'b0);
        got = rsp_rdata;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk_eq("hold_valid", rsp_valid, 1'b1);
            chk_eq("hold_rdata", rsp_rdata, exp_rd);
            chk_eq("hold_ready", req_ready, 1'b0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk_eq("hs_valid", rsp_valid, 1'b0);
        chk_eq("hs_ready", req_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, old20, addr, data;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            chk_eq("rst_ready", req_ready, 1'b0);
            chk_eq("rst_valid", rsp_valid, 1'b0);
            chk_eq("rst_rdata", rsp_rdata, 32'h0);
            chk_eq("rst_err", rsp_err, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_eq("rel_ready_pre", req_ready, 1'b0);
        @(posedge clk);
        #1;
        chk_eq("rel_ready", req_ready, 1'b1);
        chk_eq("rel_valid", rsp_valid, 1'b0);

        // Fill every word so later loads have known contents
        for (int w = 0; w < int'(DEPTH); w++)
            do_txn(1'b1, BASE + 32'(4 * w), $urandom, 4'hF, 0, got);

        // Store then load
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, got);
        chk_eq("st_rdata_zero", got, 32'h0);
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, got);
        chk_eq("ld_deadbeef", got, 32'hDEADBEEF);

        // Byte lanes
        do_txn(1'b1, 32'h30, 32'hFFFFFFFF, 4'hF, 0, got);
        do_txn(1'b1, 32'h30, 32'h11223344, 4'b0101, 0, got);
        do_txn(1'b0, 32'h30, 32'h0, 4'hF, 0, got);
`ifdef DMEM_BYTE_LANES_EN
        chk_eq("lanes_load", got, 32'hFF22FF44);
`else
        chk_eq("lanes_load", got, 32'h11223344);
`endif

        // Errors: misaligned load, out-of-range store leaves word 0 alone
        do_txn(1'b0, 32'h12, 32'h0, 4'hF, 0, got);
        chk_eq("mis_rdata", got, 32'h0);
        do_txn(1'b1, 32'(4 * DEPTH), 32'h5A5A5A5A, 4'hF, 0, got);
        do_txn(1'b0, 32'h0, 32'h0, 4'hF, 0, got);

        // Backpressure: response held five cycles, next request accepted right after
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, 5, got);
        chk_eq("bp_rdata", got, 32'hDEADBEEF);
        do_txn(1'b0, 32'h30, 32'h0, 4'hF, 0, got);

        // Reset during WAIT of a store: store is dropped
        old20     = m_mem[8];
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        @(negedge clk);
        chk_eq("mid_ready", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_eq("mid_rst_ready", req_ready, 1'b0);
        chk_eq("mid_rst_valid", rsp_valid, 1'b0);
        chk_eq("mid_rst_rdata", rsp_rdata, 32'h0);
        chk_eq("mid_rst_err", rsp_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("mid_rel_ready", req_ready, 1'b1);
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, got);
        chk_eq("mid_old_value", got, old20);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 9))
                0:       addr = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
                1:       addr = BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000);
                2:       addr = BASE - 4 * $urandom_range(1, 16);
                default: addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
            endcase
            data = $urandom;
            do_txn(1'($urandom_range(0, 1)), addr, data, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
